// File: rtl/apb_tlm_reader.sv
// rtl/apb_tlm_reader.sv - APB3 slave streaming telemetry RAM words through an auto-incrementing data register
//
// Ports:
//   PCLK        bus clock (only clock)
//   rst_tx      asynchronous active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB3 request
//   PREADY/PSLVERR/PRDATA             registered APB3 response
//   RD_TLM      telemetry RAM read data, launched by the rising edge of RCLK_TLM
//   RCLK_TLM    one-cycle RAM read strobe
//   R_ADDR_TLM  RAM read address (current pointer)
//
// Build option: TLM_PREFETCH_EN keeps the word at ptr in a local buffer so DATA
// reads answer with one wait state, refilling the buffer in the background.

module apb_tlm_reader #(
    parameter int          DATA_W     = 8,
    parameter int          ADDR_W     = 5,
    parameter int          START_ADDR = 1,
    parameter int          END_ADDR   = 31,
    parameter logic [15:0] ID_VALUE   = 16'h00AB
) (
    input  logic              PCLK,
    input  logic              rst_tx,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [15:0]       PWDATA,
    input  logic [DATA_W-1:0] RD_TLM,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [15:0]       PRDATA,
    output logic              RCLK_TLM,
    output logic [ADDR_W-1:0] R_ADDR_TLM
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [7:0] A_ID     = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_CTRL   = 8'h08;
    localparam logic [7:0] A_DATA   = 8'h0C;
    localparam logic [7:0] A_PTR    = 8'h10;

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);
    localparam logic [15:0]       END_W   = 16'(END_ADDR);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              wrap;
    logic              adv_pend;   // the response in flight is a DATA read

    logic              is_id, is_status, is_ctrl, is_data, is_ptr;
    logic              acc_err, access, hold, go;
    logic              data_rd, ptr_wr, ctrl_wr;
    logic              ptr_load, ptr_adv, wrap_set, wrap_clr;
    logic              busy;
    logic [ADDR_W-1:0] ptr_wdata, remain;
    logic [15:0]       status_word, rd_ext, rdata_mux;

`ifdef TLM_PREFETCH_EN
    logic [DATA_W-1:0] buf_data;
    logic              buf_valid;
    logic              fetch_go;
    logic [15:0]       buf_ext;
`endif

    assign R_ADDR_TLM = ptr;

    always_comb begin
        is_id     = (PADDR == A_ID);
        is_status = (PADDR == A_STATUS);
        is_ctrl   = (PADDR == A_CTRL);
        is_data   = (PADDR == A_DATA);
        is_ptr    = (PADDR == A_PTR);
        acc_err   = PWRITE ? !(is_ctrl | is_ptr)
                           : !(is_id | is_status | is_data | is_ptr);
        access    = PSEL & PENABLE & (state == ST_IDLE);
`ifdef TLM_PREFETCH_EN
        // Stall DATA reads until the buffer is valid, and stall pointer-changing
        // writes while a fetch is in flight so the RAM address stays stable.
        hold = (is_data & !PWRITE & !buf_valid)
             | (RCLK_TLM & PWRITE & (is_ptr | (is_ctrl & PWDATA[0])));
`else
        hold = 1'b0;
`endif
        go       = access & !hold;
        data_rd  = go & is_data & !PWRITE;
        ptr_wr   = go & is_ptr & PWRITE;
        ctrl_wr  = go & is_ctrl & PWRITE;
        ptr_load = ptr_wr | (ctrl_wr & PWDATA[0]);
        wrap_clr = ctrl_wr & PWDATA[1];
        ptr_adv  = (state == ST_RESP) & adv_pend;
        wrap_set = ptr_adv & (ptr == END_A);
        // Clamp against the full write value so out-of-range writes saturate.
        ptr_wdata = (PWDATA > END_W) ? END_A : PWDATA[ADDR_W-1:0];
        remain    = END_A - ptr + ADDR_W'(1);
    end

    always_comb begin
`ifdef TLM_PREFETCH_EN
        busy     = !buf_valid;
        fetch_go = !buf_valid & !RCLK_TLM & !ptr_load & !ptr_adv;
        buf_ext  = '0;
        buf_ext[DATA_W-1:0] = buf_data;
`else
        busy = 1'b0;
`endif
        rd_ext = '0;
        rd_ext[DATA_W-1:0] = RD_TLM;
        status_word = '0;
        status_word[ADDR_W-1:0] = remain;
        status_word[14] = busy;
        status_word[15] = wrap;
        rdata_mux = '0;
        if (!acc_err && !PWRITE) begin
            if (is_id)     rdata_mux = ID_VALUE;
            if (is_status) rdata_mux = status_word;
            if (is_ptr)    rdata_mux[ADDR_W-1:0] = ptr;
`ifdef TLM_PREFETCH_EN
            if (is_data)   rdata_mux = buf_ext;
`endif
        end
    end

    always_ff @(posedge PCLK or negedge rst_tx) begin
        if (!rst_tx) begin
            state    <= ST_IDLE;
            ptr      <= START_A;
            wrap     <= 1'b0;
            adv_pend <= 1'b0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PRDATA   <= '0;
            RCLK_TLM <= 1'b0;
`ifdef TLM_PREFETCH_EN
            buf_data  <= '0;
            buf_valid <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
`ifdef TLM_PREFETCH_EN
                        state    <= ST_RESP;
                        PREADY   <= 1'b1;
                        PSLVERR  <= acc_err;
                        PRDATA   <= rdata_mux;
                        adv_pend <= data_rd;
`else
                        if (data_rd) begin
                            state    <= ST_FETCH;
                            RCLK_TLM <= 1'b1;
                            adv_pend <= 1'b1;
                        end else begin
                            state    <= ST_RESP;
                            PREADY   <= 1'b1;
                            PSLVERR  <= acc_err;
                            PRDATA   <= rdata_mux;
                            adv_pend <= 1'b0;
                        end
`endif
                    end
                end
                ST_FETCH: begin
`ifndef TLM_PREFETCH_EN
                    RCLK_TLM <= 1'b0;
`endif
                    PRDATA  <= rd_ext;
                    PSLVERR <= 1'b0;
                    PREADY  <= 1'b1;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    PREADY   <= 1'b0;
                    PSLVERR  <= 1'b0;
                    adv_pend <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (ptr_load)
                ptr <= ptr_wr ? ptr_wdata : START_A;
            else if (ptr_adv)
                ptr <= (ptr == END_A) ? START_A : ptr + ADDR_W'(1);

            // A wrap in the same cycle as a clear request leaves WRAP set.
            if (wrap_set)
                wrap <= 1'b1;
            else if (wrap_clr)
                wrap <= 1'b0;

`ifdef TLM_PREFETCH_EN
            if (RCLK_TLM) begin
                RCLK_TLM  <= 1'b0;
                buf_data  <= RD_TLM;
                buf_valid <= 1'b1;
            end else if (fetch_go) begin
                RCLK_TLM <= 1'b1;
            end
            if (ptr_load | ptr_adv)
                buf_valid <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_apb_tlm_reader.sv
// tb/tb_apb_tlm_reader.sv - directed table-driven bench for apb_tlm_reader

module tb_apb_tlm_reader;

    logic        PCLK = 1'b0;
    logic        rst_tx;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [15:0] PWDATA;
    logic [7:0]  RD_TLM;
    logic        PREADY, PSLVERR;
    logic [15:0] PRDATA;
    logic        RCLK_TLM;
    logic [4:0]  R_ADDR_TLM;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

`ifdef TLM_PREFETCH_EN
    localparam int DW = 1;
`else
    localparam int DW = 2;
`endif

    apb_tlm_reader dut (
        .PCLK       (PCLK),
        .rst_tx     (rst_tx),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .RD_TLM     (RD_TLM),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .PRDATA     (PRDATA),
        .RCLK_TLM   (RCLK_TLM),
        .R_ADDR_TLM (R_ADDR_TLM)
    );

    always #5 PCLK = ~PCLK;

    // Telemetry RAM: word[a] = a ^ 8'h5A, launched on the strobe's rising edge.
    initial RD_TLM = 8'h00;
    always @(posedge RCLK_TLM) begin
        RD_TLM <= {3'b000, R_ADDR_TLM} ^ 8'h5A;
        pulses <= pulses + 1;
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
        logic [4:0]  exp_raddr;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                            input bit b2b, output logic [15:0] rdata, output logic err,
                            output int waits);
        if (!b2b) begin
            @(posedge PCLK);
            #1;
        end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        waits = 0;
        while (PREADY !== 1'b1 && waits < 20) begin
            waits++;
            @(posedge PCLK);
            #1;
        end
        rdata = PRDATA;
        err   = PSLVERR;
        if (PREADY !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%h actual=no_pready required=pready", addr);
        end
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic        er;
        int          wt;
        int          p0;

        //          wr    addr   wdata     rdata     err   waits raddr pulses
        vecs[0]  = '{1'b0, 8'h00, 16'h0000, 16'h00AB, 1'b0, 1,  5'd1,  0};
        vecs[1]  = '{1'b0, 8'h04, 16'h0000, 16'h001F, 1'b0, 1,  5'd1,  0};
        vecs[2]  = '{1'b0, 8'h0C, 16'h0000, 16'h005B, 1'b0, DW, 5'd2,  1};
        vecs[3]  = '{1'b0, 8'h0C, 16'h0000, 16'h0058, 1'b0, DW, 5'd3,  1};
        vecs[4]  = '{1'b0, 8'h0C, 16'h0000, 16'h0059, 1'b0, DW, 5'd4,  1};
        vecs[5]  = '{1'b0, 8'h10, 16'h0000, 16'h0004, 1'b0, 1,  5'd4,  0};
        vecs[6]  = '{1'b0, 8'h04, 16'h0000, 16'h001C, 1'b0, 1,  5'd4,  0};
        vecs[7]  = '{1'b1, 8'h10, 16'd31,   16'h0000, 1'b0, 1,  5'd31, 0};
        vecs[8]  = '{1'b0, 8'h0C, 16'h0000, 16'h0045, 1'b0, DW, 5'd1,  1};
        vecs[9]  = '{1'b0, 8'h04, 16'h0000, 16'h801F, 1'b0, 1,  5'd1,  0};
        vecs[10] = '{1'b1, 8'h08, 16'h0002, 16'h0000, 1'b0, 1,  5'd1,  0};
        vecs[11] = '{1'b0, 8'h04, 16'h0000, 16'h001F, 1'b0, 1,  5'd1,  0};
        vecs[12] = '{1'b1, 8'h10, 16'd40,   16'h0000, 1'b0, 1,  5'd31, 0};
        vecs[13] = '{1'b0, 8'h10, 16'h0000, 16'h001F, 1'b0, 1,  5'd31, 0};
        vecs[14] = '{1'b0, 8'h14, 16'h0000, 16'h0000, 1'b1, 1,  5'd31, 0};
        vecs[15] = '{1'b1, 8'h00, 16'h1234, 16'h0000, 1'b1, 1,  5'd31, 0};
        vecs[16] = '{1'b0, 8'h10, 16'h0000, 16'h001F, 1'b0, 1,  5'd31, 0};
        vecs[17] = '{1'b0, 8'h08, 16'h0000, 16'h0000, 1'b1, 1,  5'd31, 0};
        vecs[18] = '{1'b1, 8'h0C, 16'h0005, 16'h0000, 1'b1, 1,  5'd31, 0};
        vecs[19] = '{1'b1, 8'h08, 16'h0001, 16'h0000, 1'b0, 1,  5'd1,  0};
        vecs[20] = '{1'b1, 8'h10, 16'd5,    16'h0000, 1'b0, 1,  5'd5,  0};
        vecs[21] = '{1'b0, 8'h04, 16'h0000, 16'h001B, 1'b0, 1,  5'd5,  0};

        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        rst_tx = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_pready",  {31'b0, PREADY},   32'd0);
        chk("rst_pslverr", {31'b0, PSLVERR},  32'd0);
        chk("rst_prdata",  {16'b0, PRDATA},   32'd0);
        chk("rst_rclk",    {31'b0, RCLK_TLM}, 32'd0);
        chk("rst_raddr",   {27'b0, R_ADDR_TLM}, 32'd1);
        @(negedge PCLK);
        rst_tx = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;

        for (int i = 0; i < 22; i++) begin
            p0 = pulses;
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, wt);
            chk($sformatf("v%0d_rdata", i), {16'b0, rd}, {16'b0, vecs[i].exp_rdata});
            chk($sformatf("v%0d_err", i),   {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("v%0d_waits", i), wt, vecs[i].exp_waits);
            chk($sformatf("v%0d_pready_low", i), {31'b0, PREADY}, 32'd0);
            repeat (2) @(posedge PCLK);
            #1;
            chk($sformatf("v%0d_raddr", i), {27'b0, R_ADDR_TLM}, {27'b0, vecs[i].exp_raddr});
`ifndef TLM_PREFETCH_EN
            chk($sformatf("v%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
`endif
        end

        // Set WRAP, then clear it together with a pointer reload.
        apb_xfer(1'b1, 8'h10, 16'd31, 1'b0, rd, er, wt);
        apb_xfer(1'b0, 8'h0C, 16'h0000, 1'b0, rd, er, wt);
        chk("wrap_data", {16'b0, rd}, 32'h0045);
        apb_xfer(1'b1, 8'h08, 16'h0003, 1'b0, rd, er, wt);
        apb_xfer(1'b0, 8'h04, 16'h0000, 1'b0, rd, er, wt);
        chk("ctrl3_status", {16'b0, rd}, 32'h001F);
        apb_xfer(1'b1, 8'h10, 16'd5, 1'b0, rd, er, wt);
        apb_xfer(1'b0, 8'h04, 16'h0000, 1'b0, rd, er, wt);
        chk("pre_reset_status", {16'b0, rd}, 32'h001B);

`ifdef TLM_PREFETCH_EN
        // Back-to-back DATA reads: the second catches the refetch in flight.
        repeat (3) @(posedge PCLK);
        #1;
        apb_xfer(1'b0, 8'h0C, 16'h0000, 1'b0, rd, er, wt);
        chk("b2b_first_data",  {16'b0, rd}, 32'h005F);
        chk("b2b_first_waits", wt, 1);
        apb_xfer(1'b0, 8'h0C, 16'h0000, 1'b1, rd, er, wt);
        chk("b2b_second_data",  {16'b0, rd}, 32'h005C);
        chk("b2b_second_waits", wt, 2);
        apb_xfer(1'b1, 8'h10, 16'd5, 1'b0, rd, er, wt);
        repeat (3) @(posedge PCLK);
        #1;
`endif

        // Reset in the middle of a DATA read at ptr=5.
        @(posedge PCLK);
        #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h0C;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        @(posedge PCLK);
        #2;
`ifndef TLM_PREFETCH_EN
        chk("mid_rclk_high", {31'b0, RCLK_TLM}, 32'd1);
`endif
        rst_tx = 1'b0;
        #1;
        chk("abort_rclk",    {31'b0, RCLK_TLM}, 32'd0);
        chk("abort_pready",  {31'b0, PREADY},   32'd0);
        chk("abort_pslverr", {31'b0, PSLVERR},  32'd0);
        chk("abort_prdata",  {16'b0, PRDATA},   32'd0);
        chk("abort_raddr",   {27'b0, R_ADDR_TLM}, 32'd1);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        rst_tx = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        apb_xfer(1'b0, 8'h10, 16'h0000, 1'b0, rd, er, wt);
        chk("post_reset_ptr", {16'b0, rd}, 32'h0001);
        apb_xfer(1'b0, 8'h0C, 16'h0000, 1'b0, rd, er, wt);
        chk("post_reset_data", {16'b0, rd}, 32'h005B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
